// File: rtl/nmx1_wb_bridge.sv
// nmx1_wb_bridge: windowed Wishbone front-end for Neuromorphic_X1_wb with timeout abort and status register
module nmx1_wb_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_0000,
  parameter logic [15:0] STAT_OFFSET = 16'hFFFC,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] TO_DATA     = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [15:0] WLAST = 16'(TIMEOUT - 1);
  state_t      state, state_n;
  logic [15:0] wcnt, wcnt_n, tcnt, tcnt_n;
  logic        ack_n, to_n, stb_n, we_n;
  logic [3:0]  sel_n;
  logic [31:0] adr_n, mdat_n, dat_n;
  logic        req, stat;
  assign req     = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign stat    = wbs_adr_i[15:0] == STAT_OFFSET;
  assign m_cyc_o = m_stb_o;
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    tcnt_n  = tcnt;
    ack_n   = 1'b0;
    to_n    = 1'b0;
    dat_n   = 32'b0;
    stb_n   = m_stb_o;
    we_n    = m_we_o;
    sel_n   = m_sel_o;
    adr_n   = m_adr_o;
    mdat_n  = m_dat_o;
    case (state)
      IDLE: if (req && stat) begin
        state_n = RESP;
        ack_n   = 1'b1;
        dat_n   = wbs_we_i ? 32'b0 : {16'b0, tcnt};
        tcnt_n  = wbs_we_i ? 16'b0 : tcnt;
      end else if (req) begin
        state_n = REQ;
        stb_n   = 1'b1;
        we_n    = wbs_we_i;
        sel_n   = wbs_sel_i;
        adr_n   = wbs_adr_i;
        mdat_n  = wbs_dat_i;
        wcnt_n  = 16'b0;
      end
      REQ: begin
        wcnt_n = wcnt + 16'd1;
        // master abort outranks a late core ack: nobody is left to receive it
        if (!wbs_cyc_i) begin
          state_n = IDLE;
          stb_n   = 1'b0;
        end else if (m_ack_i || wcnt == WLAST) begin
          state_n = RESP;
          stb_n   = 1'b0;
          ack_n   = 1'b1;
          to_n    = !m_ack_i;
          dat_n   = m_ack_i ? m_dat_i : (m_we_o ? 32'b0 : TO_DATA);
          tcnt_n  = (m_ack_i || tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wcnt      <= 16'b0;
      tcnt      <= 16'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'b0;
      timeout_o <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_sel_o   <= 4'b0;
      m_adr_o   <= 32'b0;
      m_dat_o   <= 32'b0;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      tcnt      <= tcnt_n;
      wbs_ack_o <= ack_n;
      wbs_dat_o <= dat_n;
      timeout_o <= to_n;
      m_stb_o   <= stb_n;
      m_we_o    <= we_n;
      m_sel_o   <= sel_n;
      m_adr_o   <= adr_n;
      m_dat_o   <= mdat_n;
    end
  end
endmodule

// File: tb/tb_nmx1_wb_bridge.sv
// tb_nmx1_wb_bridge: scoreboard bench with a delay-programmable core model and a transaction-level reference
module tb_nmx1_wb_bridge;
  localparam int T = 8;
  localparam logic [31:0] TOD = 32'hDEAD_BEEF;
  localparam int NEVER = 255;
  logic clk = 1'b0, rst = 1'b1;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'b0;
  logic [31:0] adr = 32'b0, wdat = 32'b0;
  logic ack, m_stb, m_cyc, m_we, to;
  logic [31:0] rdat, m_adr, m_dat;
  logic [3:0] m_sel;
  logic m_ack = 1'b0;
  logic [31:0] m_rdat = 32'b0;
  int checks = 0, failures = 0, cyc_cnt = 0;
  typedef struct {logic [31:0] data; bit care; int start; int lat; bit to;} exp_t;
  exp_t sb[$];
  logic [15:0] tcnt_m = 16'b0;
  bit core_exp = 0;
  int cdly = NEVER, ccnt = 0;
  logic [31:0] cdat, e_adr, e_dat;
  logic e_we;
  logic [3:0] e_sel;
  bit prev_ack = 0;

  nmx1_wb_bridge #(.TIMEOUT(T)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .m_stb_o(m_stb), .m_cyc_o(m_cyc), .m_we_o(m_we), .m_sel_o(m_sel), .m_adr_o(m_adr),
    .m_dat_o(m_dat), .m_ack_i(m_ack), .m_dat_i(m_rdat), .timeout_o(to)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  // core model: acks cdly cycles after strobe appears, checks the forwarded request once
  always @(negedge clk) begin
    if (m_ack) m_ack = 1'b0;
    else if (m_stb && !rst) begin
      if (ccnt == 0) begin
        chk("core_expected", {31'b0, core_exp}, 32'd1);
        chk("m_adr", m_adr, e_adr);
        chk("m_we", {31'b0, m_we}, {31'b0, e_we});
        chk("m_sel", {28'b0, m_sel}, {28'b0, e_sel});
        if (e_we) chk("m_dat", m_dat, e_dat);
      end
      if (ccnt == cdly) begin
        m_ack = 1'b1;
        m_rdat = cdat;
      end
      ccnt++;
    end else ccnt = 0;
  end

  always @(negedge clk) begin
    if (rst) prev_ack = 0;
    else begin
      if (ack) begin
        exp_t e;
        if (prev_ack) chk("ack_consecutive", 32'd1, 32'd0);
        if (sb.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("latency", cyc_cnt - e.start + 1, e.lat);
          chk("timeout_o", {31'b0, to}, {31'b0, e.to});
          if (e.care) chk("rdata", rdat, e.data);
        end
      end else if (to) chk("timeout_stray", 32'd1, 32'd0);
      prev_ack = ack;
    end
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; adr = a; wdat = d; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
  endtask

  task automatic release_bus();
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int dly, input logic [31:0] cd);
    exp_t e;
    int n;
    bit stat;
    stat = a[15:0] == 16'hFFFC;
    if ((a & 32'hFFFF_0000) != 32'h3000_0000) begin
      bit bad = 0;
      drive(w, a, d);
      repeat (20) begin
        @(negedge clk);
        if (m_stb || ack) bad = 1;
      end
      chk("out_of_window_quiet", {31'b0, bad}, 32'd0);
      release_bus();
      @(negedge clk);
      return;
    end
    e.start = cyc_cnt;
    e.care = 1;
    e.to = 0;
    if (stat) begin
      e.lat = 2;
      e.data = w ? 32'b0 : {16'b0, tcnt_m};
      if (w) tcnt_m = 16'b0;
    end else if (dly < T) begin
      e.lat = dly + 3;
      e.data = cd;
      e.care = !w;
    end else begin
      e.lat = T + 2;
      e.data = w ? 32'b0 : TOD;
      e.to = 1;
      tcnt_m = (tcnt_m == 16'hFFFF) ? tcnt_m : tcnt_m + 16'd1;
    end
    core_exp = !stat; cdly = dly; cdat = cd; e_adr = a; e_dat = d; e_we = w; e_sel = 4'hF;
    sb.push_back(e);
    drive(w, a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 100);
    if (!ack) chk("ack_wait", 32'd0, 32'd1);
    release_bus();
    core_exp = 0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic start_hung_read(input logic [31:0] a);
    int n = 0;
    core_exp = 1; cdly = NEVER; e_adr = a; e_we = 0; e_sel = 4'hF;
    drive(1'b0, a, 32'b0);
    while (!m_stb && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("hung_req_started", {31'b0, m_stb}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {ack, m_stb, m_cyc, m_we, to, m_sel}, 32'd0);
    chk("reset_data", rdat | m_adr | m_dat, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {ack, m_stb, m_cyc, to}, 32'd0);
    xact(1, 32'h3000_0010, 32'h1234_5678, 2, 32'h0);
    xact(0, 32'h3000_FFFC, 0, 0, 0);
    xact(0, 32'h3000_0020, 0, 0, 32'hCAFE_0001);
    xact(0, 32'h3000_0030, 0, NEVER, 32'h0);
    xact(0, 32'h3000_FFFC, 0, 0, 0);
    xact(0, 32'h3000_0040, 0, T - 1, 32'h5555_AAAA);
    xact(0, 32'h3000_FFFC, 0, 0, 0);
    xact(1, 32'h3000_0044, 32'h0BAD_F00D, NEVER, 0);
    xact(0, 32'h2000_0000, 0, 0, 0);
    xact(1, 32'h3000_FFFC, 0, 0, 0);
    xact(0, 32'h3000_FFFC, 0, 0, 0);
    start_hung_read(32'h3000_0050);
    #2 rst = 1'b1;
    #1 chk("async_reset_drop", {29'b0, m_stb, m_cyc, ack}, 32'd0);
    @(negedge clk);
    release_bus();
    core_exp = 0;
    tcnt_m = 16'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xact(0, 32'h3000_0060, 0, NEVER, 0);
    start_hung_read(32'h3000_0070);
    cyc = 1'b0;
    stb = 1'b0;
    @(negedge clk);
    chk("abort_m_cyc", {30'b0, m_cyc, m_stb}, 32'd0);
    core_exp = 0;
    repeat (15) @(negedge clk);
    xact(0, 32'h3000_FFFC, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      int k, r;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      r = $urandom_range(0, 11);
      a = {16'h3000, 16'($urandom) & 16'hFFF8};
      if (k == 0) xact(0, 32'h3000_FFFC, 0, 0, 0);
      else if (k == 1) xact(1, 32'h3000_FFFC, $urandom, 0, 0);
      else if (k == 2 && i % 4 == 0) xact(0, 32'h3100_0000 | ($urandom & 32'hFFFF), 0, 0, 0);
      else xact(1'($urandom), a, $urandom, r > 9 ? NEVER : r, $urandom);
    end
    xact(0, 32'h3000_FFFC, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nmx1_wb_bridge.md
Name: nmx1_wb_bridge

Overview:
- Wishbone front-end placed directly upstream of the Neuromorphic_X1_wb core inside user_project_wrapper.
- Decodes the Caravel user-space address window and registers each request toward the core.
- Holds the request until the core acks, or aborts it after a bounded timeout and returns an error word, so a stalled macro cannot hang the management SoC.
- Provides one local status register holding a saturating timeout counter.

Parameters:
- BASE_ADDR, 32'h3000_0000, window base address.
- ADDR_MASK, 32'hFFFF_0000, window match mask: in window when (wbs_adr_i & ADDR_MASK) == BASE_ADDR.
- STAT_OFFSET, 16'hFFFC, low-16 address offset of the local status register (not forwarded to the core).
- TIMEOUT, 255, cycles in REQ without m_ack_i before abort; range 1..65535.
- TO_DATA, 32'hDEAD_BEEF, read data returned on a timed-out read.

Ports:
- wb_clk_i  in  1  bus clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i  in  1  upstream strobe.
- wbs_cyc_i  in  1  upstream cycle.
- wbs_we_i  in  1  upstream write enable.
- wbs_sel_i  in  4  upstream byte selects.
- wbs_adr_i  in  32  upstream address.
- wbs_dat_i  in  32  upstream write data.
- wbs_ack_o  out  1  upstream ack.
- wbs_dat_o  out  32  upstream read data.
- m_stb_o  out  1  strobe to core.
- m_cyc_o  out  1  cycle to core.
- m_we_o  out  1  write enable to core.
- m_sel_o  out  4  byte selects to core.
- m_adr_o  out  32  address to core (full address, unmodified).
- m_dat_o  out  32  write data to core.
- m_ack_i  in  1  ack from core.
- m_dat_i  in  32  read data from core.
- timeout_o  out  1  one-cycle pulse on each abort.

Behaviour:
- Reset: one clock; reset asynchronous, active-high, on wb_rst_i. All outputs are 0. FSM goes to IDLE. Timeout counter (tcnt, 16 bit) and wait counter are cleared.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. No ack is issued.
- Request definition: req = wbs_cyc_i & wbs_stb_i & in_window.
- Out-of-window requests: ignored; never acked by this block.
- States: IDLE, REQ, RESP.
- IDLE, req and offset == STAT_OFFSET:
  - Read: wbs_dat_o = {16'b0, tcnt}.
  - Write: clears tcnt; wbs_dat_o = 0.
  - Go to RESP. Core is not accessed.
- IDLE, other req:
  - Register we/sel/adr/dat into m_* outputs.
  - Assert m_stb_o = m_cyc_o = 1.
  - Clear wait counter; go to REQ.
- REQ:
  - Hold m_* stable. Wait counter increments each cycle.
  - m_ack_i = 1: deassert m_stb/m_cyc next edge; capture m_dat_i into wbs_dat_o (writes also capture it; value is don't-care); go to RESP.
  - Wait counter reaches TIMEOUT-1 with no ack: deassert m_stb/m_cyc; wbs_dat_o = TO_DATA on reads, 0 on writes; pulse timeout_o; tcnt += 1, saturating at 16'hFFFF; go to RESP.
  - m_ack_i and timeout in the same cycle: ack wins; no timeout pulse, no tcnt increment.
  - wbs_cyc_i drops while in REQ (master abort): deassert m_stb/m_cyc next edge, go to IDLE, no upstream ack, tcnt unchanged.
- RESP:
  - wbs_ack_o = 1 for exactly one cycle.
  - wbs_dat_o holds its value during the ack cycle and returns to 0 on the following cycle.
  - Next state is IDLE.
  - A new request can be accepted no earlier than the cycle after RESP.
- Latency, core access: first m_stb_o at edge 1 after req. Core acks at edge k of REQ; wbs_ack_o is high in cycle k+1.
  - Minimum upstream latency: 3 cycles from req to ack (core acks in the first REQ cycle).
- Latency, status access: wbs_ack_o in cycle 2 after req.
- Latency, timeout: wbs_ack_o exactly TIMEOUT+2 cycles after req.
- m_ack_i outside REQ: ignored.
- wbs_ack_o never asserts on two consecutive cycles.

Test Plan:
- Reset, then write 32'h1234_5678 to 32'h3000_0010 (sel=4'hF); core model acks 2 cycles after stb → m_adr_o=32'h3000_0010, m_dat_o=32'h1234_5678, m_we_o=1 while in REQ; single wbs_ack_o; tcnt=0.
- Read 32'h3000_0020 with core returning 32'hCAFE_0001 on an immediate ack → wbs_dat_o=32'hCAFE_0001 with wbs_ack_o, exactly 3 cycles after req.
- Read with core never acking, TIMEOUT=8 → one timeout_o pulse; wbs_ack_o at cycle 10 with wbs_dat_o=32'hDEAD_BEEF; a status read of 32'h3000_FFFC then returns 32'h0000_0001.
- Core ack in the same cycle the timeout would fire → core data returned, no timeout_o, tcnt unchanged.
- Request to 32'h2000_0000 → no m_stb_o and no wbs_ack_o for 20 cycles; then write to 32'h3000_FFFC → ack in cycle 2, and tcnt reads back 0.
- Assert wb_rst_i asynchronously mid-REQ → m_stb_o, m_cyc_o and wbs_ack_o drop to 0 immediately; separately, dropping wbs_cyc_i in REQ → m_cyc_o=0 next edge, no ack.
